mips_mem_responder: RTL

Memory-side responder for the MIPS32 pipelined core. It serves instruction-fetch reads and data-memory loads and stores, replacing direct array indexing inside the core.
- Holds a word-addressed 1024x32 unified array shared by program and data.
- Exposes two valid/ready request channels: IF for fetch, DM for LW/SW.
- Returns each response after a fixed, parameterised latency.
- Allows one outstanding transaction; DM has priority over IF.

---
 rtl/mips_mem_pkg.sv | 16 +
 rtl/mips_mem_array.sv | 27 ++
 rtl/mips_mem_responder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared widths, state encoding and channel ids for the memory responder
package mips_mem_pkg;

    localparam int MEM_ADDR_W = 10;
    localparam int MEM_DATA_W = 32;
    localparam int CNT_W      = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic CH_IF = 1'b0;
    localparam logic CH_DM = 1'b1;

endpackage

// File: rtl/mips_mem_array.sv
// rtl/mips_mem_array.sv - 1R1W unified program/data store, synchronous write, asynchronous read
module mips_mem_array
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    // Contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/mips_mem_responder.sv
// rtl/mips_mem_responder.sv - fixed-latency IF/DM memory responder, one outstanding transaction
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              dm_req_valid,
    output logic              dm_req_ready,
    input  logic              dm_req_we,
    input  logic [ADDR_W-1:0] dm_req_addr,
    input  logic [DATA_W-1:0] dm_req_wdata,
    output logic              dm_rsp_valid,
    output logic [DATA_W-1:0] dm_rsp_data,
    output logic              busy
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ch;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic              w_acc_dm;
    logic              w_acc_if;
    logic              w_done;
    logic              w_mem_we;
    logic [DATA_W-1:0] w_rdata;

    // DM wins over IF: the MEM-stage access is older than the fetch.
    always_comb begin
        w_state_nxt  = r_state;
        dm_req_ready = 1'b0;
        if_req_ready = 1'b0;
        w_acc_dm     = 1'b0;
        w_acc_if     = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                dm_req_ready = 1'b1;
                if_req_ready = ~dm_req_valid;
                w_acc_dm     = dm_req_valid;
                w_acc_if     = if_req_valid & ~dm_req_valid;
                if (dm_req_valid || if_req_valid) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stores commit at acceptance so any later read sees them.
    assign w_mem_we = w_acc_dm & dm_req_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_ch         <= CH_IF;
            r_we         <= 1'b0;
            r_addr       <= '0;
            busy         <= 1'b0;
            if_rsp_valid <= 1'b0;
            dm_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            dm_rsp_data  <= '0;
        end else begin
            if_rsp_valid <= 1'b0;
            dm_rsp_valid <= 1'b0;
            if (w_acc_dm || w_acc_if) begin
                r_ch   <= w_acc_dm ? CH_DM : CH_IF;
                r_we   <= w_acc_dm & dm_req_we;
                r_addr <= w_acc_dm ? dm_req_addr : if_req_addr;
                r_cnt  <= CNT_W'(LAT - 1);
                busy   <= 1'b1;
            end else if (r_state == WAIT) begin
                if (!w_done) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end else begin
                    busy <= 1'b0;
                    if (r_ch == CH_DM) begin
                        dm_rsp_valid <= 1'b1;
                        dm_rsp_data  <= r_we ? '0 : w_rdata;
                    end else begin
                        if_rsp_valid <= 1'b1;
                        if_rsp_data  <= w_rdata;
                    end
                end
            end
        end
    end

    mips_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (w_mem_we),
        .waddr (dm_req_addr),
        .wdata (dm_req_wdata),
        .raddr (r_addr),
        .rdata (w_rdata)
    );

endmodule
